rv_pc_fetch: RTL

Parametrised program-counter and instruction-fetch unit for the rv_core cores. Holds the architectural PC and issues one outstanding request at a time on a req/gnt/rvalid instruction-memory interface. Resolves jal/jalr/branch redirects internally and squashes in-flight fetches on redirect. Delivers {instr, pc} to decode over a valid/ready handshake.

---
 rtl/rv_pc_fetch.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/rv_pc_fetch.sv
// rv_pc_fetch: program counter and single-outstanding instruction fetch unit.
// Holds the architectural PC, issues one req/gnt/rvalid fetch at a time,
// resolves jal/jalr/branch redirects, squashes in-flight fetches on redirect
// and hands {instr, pc} to decode over a valid/ready handshake.
// Optional build macro RV_PC_PERF_EN adds fetch/kill event counters.
module rv_pc_fetch #(
    parameter int                    ADDR_WIDTH   = 64,
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    INSTR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_en_i,
    input  logic                   b_type_i,
    input  logic                   cond_i,
    input  logic                   jalr_sel_i,
    input  logic [ADDR_WIDTH-1:0]  src_pc_i,
    input  logic [DATA_WIDTH-1:0]  base_i,
    input  logic [DATA_WIDTH-1:0]  imm_i,
    output logic                   imem_req_o,
    output logic [ADDR_WIDTH-1:0]  imem_addr_o,
    input  logic                   imem_gnt_i,
    input  logic                   imem_rvalid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
    output logic                   instr_valid_o,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0]  instr_pc_o,
    input  logic                   instr_ready_i,
    output logic                   misalign_o
`ifdef RV_PC_PERF_EN
    ,
    output logic [31:0]            fetch_cnt_o,
    output logic [31:0]            kill_cnt_o
`endif
);

    localparam int SUM_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic                   kill_q, kill_d;
    logic                   run_q;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]  ipc_q, ipc_d;
    logic                   mis_q, mis_d;

    logic                   taken;
    logic [ADDR_WIDTH-1:0]  target;
    logic                   misalign_hit;

    // Redirect target, modulo 2^ADDR_WIDTH. jalr clears bit 0 of rs1+imm;
    // jal/branch offsets are in half-words, hence the shift by one.
    function automatic logic [ADDR_WIDTH-1:0] calc_target(
        input logic                          jalr,
        input logic        [ADDR_WIDTH-1:0]  src_pc,
        input logic signed [DATA_WIDTH-1:0]  base,
        input logic signed [DATA_WIDTH-1:0]  imm
    );
        logic signed [SUM_W-1:0] imm_x;
        logic signed [SUM_W-1:0] base_x;
        logic signed [SUM_W-1:0] src_x;
        logic signed [SUM_W-1:0] sum;
        imm_x  = SUM_W'(imm);
        base_x = SUM_W'(base);
        src_x  = SUM_W'(src_pc);
        if (jalr) begin
            sum    = base_x + imm_x;
            sum[0] = 1'b0;
        end else begin
            sum = src_x + (imm_x <<< 1);
        end
        return sum[ADDR_WIDTH-1:0];
    endfunction

    assign taken        = redirect_en_i & (cond_i | ~b_type_i);
    assign target       = calc_target(jalr_sel_i, src_pc_i, base_i, imm_i);
    assign misalign_hit = taken && (target[1:0] != 2'b00) && (state_q != S_HALT);

    // The request is held off for the first cycle out of reset via run_q.
    assign imem_req_o    = run_q && (state_q == S_REQ);
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = (state_q == S_HOLD);
    assign instr_o       = instr_q;
    assign instr_pc_o    = ipc_q;
    assign misalign_o    = mis_q;

    // Next-state, PC, kill and held-instruction update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        mis_d   = mis_q;
        if (misalign_hit) begin
            // Misaligned target: stop fetching for good, drop anything pending.
            mis_d   = 1'b1;
            kill_d  = 1'b0;
            state_d = S_HALT;
        end else begin
            case (state_q)
                S_REQ: begin
                    // Address only moves while the request is not being granted,
                    // except a same-cycle redirect, which then kills that fetch.
                    if (run_q && imem_gnt_i) begin
                        state_d = S_WAIT;
                    end
                    if (taken) begin
                        pc_d = target;
                        if (run_q && imem_gnt_i) begin
                            kill_d = 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (kill_q || taken) begin
                            kill_d  = 1'b0;
                            state_d = S_REQ;
                            if (taken) begin
                                pc_d = target;
                            end
                        end else begin
                            instr_d = imem_rdata_i;
                            ipc_d   = pc_q;
                            pc_d    = pc_q + ADDR_WIDTH'(4);
                            state_d = S_HOLD;
                        end
                    end else if (taken) begin
                        pc_d   = target;
                        kill_d = 1'b1;
                    end
                end
                S_HOLD: begin
                    // A redirect wins over decode accepting the held instruction.
                    if (taken) begin
                        pc_d    = target;
                        state_d = S_REQ;
                    end else if (instr_ready_i) begin
                        state_d = S_REQ;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_HALT;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_VECTOR;
            kill_q  <= 1'b0;
            run_q   <= 1'b0;
            instr_q <= '0;
            ipc_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            run_q   <= 1'b1;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            mis_q   <= mis_d;
        end
    end

`ifdef RV_PC_PERF_EN
    logic fetch_fire;
    logic kill_fire;

    assign fetch_fire = (state_q == S_HOLD) && instr_ready_i && !taken;
    assign kill_fire  = !misalign_hit &&
                        (((state_q == S_WAIT) && imem_rvalid_i && (kill_q || taken)) ||
                         ((state_q == S_HOLD) && taken));

    // Decode-handshake and discarded-fetch counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_o <= '0;
            kill_cnt_o  <= '0;
        end else begin
            if (fetch_fire) begin
                fetch_cnt_o <= fetch_cnt_o + 32'd1;
            end
            if (kill_fire) begin
                kill_cnt_o <= kill_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
